// File: rtl/if_id_ex_pipe.sv
// IF/ID and ID/EX pipeline registers with the EX-stage PC adders.
// Optional macro PIPE_RS_IDX_EN adds source-register indices for forwarding.
module if_id_ex_pipe #(
    parameter int                XLEN       = 32,
    parameter int                ALU_CTRL_W = 4,
    parameter logic [XLEN-1:0]   NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [XLEN-1:0]       if_instr_in,
    input  logic [XLEN-1:0]       if_pc_in,
    output logic [XLEN-1:0]       id_instr_out,
    output logic [XLEN-1:0]       id_pc_out,
    output logic                  id_valid_out,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [4:0]            id_rd,
    input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
    input  logic                  id_alu_src,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
`ifdef PIPE_RS_IDX_EN
    input  logic [4:0]            id_rs1_idx,
    input  logic [4:0]            id_rs2_idx,
    output logic [4:0]            ex_rs1_idx,
    output logic [4:0]            ex_rs2_idx,
`endif
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1,
    output logic [XLEN-1:0]       ex_rs2,
    output logic [XLEN-1:0]       ex_imm,
    output logic [4:0]            ex_rd,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc_plus_imm,
    output logic [XLEN-1:0]       ex_pc_plus_4
);

    // IF/ID: flush squashes to a NOP, stall holds the current instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_instr_out <= NOP_INSTR;
            id_pc_out    <= '0;
            id_valid_out <= 1'b0;
        end else if (flush) begin
            id_instr_out <= NOP_INSTR;
            id_pc_out    <= '0;
            id_valid_out <= 1'b0;
        end else if (!stall) begin
            id_instr_out <= if_instr_in;
            id_pc_out    <= if_pc_in;
            id_valid_out <= 1'b1;
        end
    end

    // ID/EX: both stall and flush insert an all-zero bubble, data included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_pc         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_imm        <= '0;
            ex_rd         <= '0;
            ex_alu_ctrl   <= '0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_valid      <= 1'b0;
        end else if (flush || stall) begin
            ex_pc         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_imm        <= '0;
            ex_rd         <= '0;
            ex_alu_ctrl   <= '0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_valid      <= 1'b0;
        end else begin
            ex_pc         <= id_pc_out;
            ex_rs1        <= id_rs1_data;
            ex_rs2        <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_rd         <= id_rd;
            ex_alu_ctrl   <= id_alu_ctrl;
            ex_alu_src    <= id_alu_src;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_valid      <= id_valid_out;
        end
    end

`ifdef PIPE_RS_IDX_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_rs1_idx <= '0;
            ex_rs2_idx <= '0;
        end else if (flush || stall) begin
            ex_rs1_idx <= '0;
            ex_rs2_idx <= '0;
        end else begin
            ex_rs1_idx <= id_rs1_idx;
            ex_rs2_idx <= id_rs2_idx;
        end
    end
`endif

    // Modulo-2^XLEN adders; the carry out is intentionally dropped.
    assign ex_pc_plus_imm = ex_pc + ex_imm;
    assign ex_pc_plus_4   = ex_pc + XLEN'(4);

endmodule

// File: tb/tb_if_id_ex_pipe.sv
// Self-checking bench for if_id_ex_pipe: directed scenarios then random traffic.
// Honours PIPE_RS_IDX_EN when the design is built with it.
module tb_if_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [31:0] if_instr_in, if_pc_in;
    logic [31:0] id_instr_out, id_pc_out;
    logic        id_valid_out;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic        ex_valid;
    logic [31:0] ex_pc_plus_imm, ex_pc_plus_4;
`ifdef PIPE_RS_IDX_EN
    logic [4:0]  id_rs1_idx, id_rs2_idx, ex_rs1_idx, ex_rs2_idx;
    logic [4:0]  m_rs1_idx, m_rs2_idx;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference state: what each stage should hold, per the pipeline rules.
    logic [31:0] m_id_instr, m_id_pc;
    logic        m_id_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;
    logic [3:0]  m_alu;
    logic        m_src, m_mr, m_mw, m_rw, m_m2r, m_valid;

    if_id_ex_pipe dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_instr_in(if_instr_in), .if_pc_in(if_pc_in),
        .id_instr_out(id_instr_out), .id_pc_out(id_pc_out), .id_valid_out(id_valid_out),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
`ifdef PIPE_RS_IDX_EN
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .ex_rs1_idx(ex_rs1_idx), .ex_rs2_idx(ex_rs2_idx),
`endif
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_valid(ex_valid), .ex_pc_plus_imm(ex_pc_plus_imm), .ex_pc_plus_4(ex_pc_plus_4)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ex_model();
        m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0; m_alu = 0;
        m_src = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_valid = 0;
`ifdef PIPE_RS_IDX_EN
        m_rs1_idx = 0; m_rs2_idx = 0;
`endif
    endtask

    task automatic model_reset();
        m_id_instr = 32'h00000013; m_id_pc = 0; m_id_valid = 0;
        clear_ex_model();
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    // One rising edge: EX takes the old IF/ID contents, then IF/ID updates.
    task automatic model_edge();
        if (flush || stall) begin
            clear_ex_model();
        end else begin
            m_pc = m_id_pc; m_rs1 = id_rs1_data; m_rs2 = id_rs2_data; m_imm = id_imm;
            m_rd = id_rd; m_alu = id_alu_ctrl; m_src = id_alu_src; m_mr = id_mem_read;
            m_mw = id_mem_write; m_rw = id_reg_write; m_m2r = id_mem_to_reg;
            m_valid = m_id_valid;
`ifdef PIPE_RS_IDX_EN
            m_rs1_idx = id_rs1_idx; m_rs2_idx = id_rs2_idx;
`endif
        end
        if (flush) begin
            m_id_instr = 32'h00000013; m_id_pc = 0; m_id_valid = 0;
        end else if (!stall) begin
            m_id_instr = if_instr_in; m_id_pc = if_pc_in; m_id_valid = 1;
        end
        exp_q.push_back(m_pc + m_imm);
    endtask

    task automatic check_all(input string ctx);
        logic [31:0] exp_sum;
        chk({ctx, ".id_instr"}, id_instr_out, m_id_instr);
        chk({ctx, ".id_pc"}, id_pc_out, m_id_pc);
        chk({ctx, ".id_valid"}, 32'(id_valid_out), 32'(m_id_valid));
        chk({ctx, ".ex_pc"}, ex_pc, m_pc);
        chk({ctx, ".ex_rs1"}, ex_rs1, m_rs1);
        chk({ctx, ".ex_rs2"}, ex_rs2, m_rs2);
        chk({ctx, ".ex_imm"}, ex_imm, m_imm);
        chk({ctx, ".ex_rd"}, 32'(ex_rd), 32'(m_rd));
        chk({ctx, ".ex_ctrl"},
            32'({ex_alu_ctrl, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}),
            32'({m_alu, m_src, m_mr, m_mw, m_rw, m_m2r}));
        chk({ctx, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
`ifdef PIPE_RS_IDX_EN
        chk({ctx, ".ex_rs_idx"}, 32'({ex_rs1_idx, ex_rs2_idx}), 32'({m_rs1_idx, m_rs2_idx}));
`endif
        if (exp_q.size() == 0) begin
            chk({ctx, ".scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp_sum = exp_q.pop_front();
            chk({ctx, ".ex_pc_plus_imm"}, ex_pc_plus_imm, exp_sum);
        end
        chk({ctx, ".ex_pc_plus_4"}, ex_pc_plus_4, m_pc + 32'd4);
    endtask

    task automatic tick(input string ctx);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic drive_id(input logic [31:0] imm, input logic [4:0] rd, input logic rw);
        id_rs1_data = 0; id_rs2_data = 0; id_imm = imm; id_rd = rd; id_alu_ctrl = 0;
        id_alu_src = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = rw; id_mem_to_reg = 0;
`ifdef PIPE_RS_IDX_EN
        id_rs1_idx = 0; id_rs2_idx = 0;
`endif
    endtask

    task automatic drive_rand();
        if_instr_in = $urandom; if_pc_in = $urandom;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rd = 5'($urandom); id_alu_ctrl = 4'($urandom);
        id_alu_src = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
`ifdef PIPE_RS_IDX_EN
        id_rs1_idx = 5'($urandom); id_rs2_idx = 5'($urandom);
`endif
        stall = ($urandom_range(0, 99) < 20);
        flush = ($urandom_range(0, 99) < 10);
    endtask

    initial begin
        rst = 1'b0; stall = 0; flush = 0;
        drive_rand();
        stall = 0; flush = 0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        check_all("reset");
        rst = 1'b1;

        // Basic flow: addi x1,x0,5 at pc 0x10
        stall = 0; flush = 0;
        if_instr_in = 32'h00500093; if_pc_in = 32'h10; drive_id(0, 0, 0);
        tick("flow1");
        chk("flow1.instr_const", id_instr_out, 32'h00500093);
        if_instr_in = 32'h00000013; if_pc_in = 32'h14; drive_id(5, 1, 1);
        tick("flow2");
        chk("flow2.pc_plus_imm_const", ex_pc_plus_imm, 32'h15);
        chk("flow2.pc_plus_4_const", ex_pc_plus_4, 32'h14);
        chk("flow2.valid_const", 32'(ex_valid), 32'd1);

        // Stall holds IF/ID at 0x20 and bubbles EX
        if_pc_in = 32'h20; if_instr_in = 32'h00100113; drive_id(7, 2, 1);
        tick("pre_stall");
        stall = 1; if_pc_in = 32'h24; id_mem_write = 1;
        tick("stall");
        chk("stall.id_pc_const", id_pc_out, 32'h20);
        chk("stall.reg_write_const", 32'(ex_reg_write), 32'd0);
        stall = 0; drive_id(3, 4, 1);
        tick("post_stall");
        chk("post_stall.ex_pc_const", ex_pc, 32'h20);

        // Flush wins over stall
        flush = 1; stall = 1; id_reg_write = 1; id_mem_write = 1;
        tick("flush_stall");
        chk("flush.instr_const", id_instr_out, 32'h00000013);
        flush = 0; stall = 0;

        // Adder wrap and negative immediate
        if_pc_in = 32'hFFFFFFFC; drive_id(0, 0, 0);
        tick("wrap_load");
        if_pc_in = 32'h100; drive_id(8, 0, 0);
        tick("wrap");
        chk("wrap.sum_const", ex_pc_plus_imm, 32'h00000004);
        drive_id(32'hFFFFFFF0, 0, 0);
        tick("neg_imm");
        chk("neg_imm.sum_const", ex_pc_plus_imm, 32'h000000F0);

`ifdef PIPE_RS_IDX_EN
        drive_id(0, 0, 0); id_rs1_idx = 3; id_rs2_idx = 7;
        tick("idx");
        chk("idx.const", 32'({ex_rs1_idx, ex_rs2_idx}), 32'({5'd3, 5'd7}));
        stall = 1;
        tick("idx_stall");
        stall = 0;
`endif

        for (int i = 0; i < 200; i++) begin
            drive_rand();
            tick("random");
        end

        // Asynchronous reset asserted mid-cycle
        drive_rand();
        stall = 0; flush = 0;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            tick("after_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_ex_pipe.md
Name: if_id_ex_pipe

Overview:
- Front-end pipeline register block of the five-stage RV32 core.
- Holds the IF/ID register (fetched instruction and PC) and the ID/EX register (decoded operands, immediate, destination, control bits).
- Contains the EX-stage AUIPC/branch-target adder, which computes ex_pc + ex_imm.
- Sits between fetch/decode/register-file and the ALU/memory/writeback logic. Supports stall (load-use bubble) and flush (taken branch/jump).

Parameters:
- XLEN, 32, datapath width of PC, instruction, operands, immediate.
- ALU_CTRL_W, 4, width of the ALU control field.
- NOP_INSTR, 32'h00000013, instruction injected on reset and flush (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- stall  in  1  hold IF/ID; insert bubble into ID/EX.
- flush  in  1  squash both stages.
- if_instr_in  in  XLEN  instruction from instruction memory.
- if_pc_in  in  XLEN  PC of that instruction.
- id_instr_out  out  XLEN  registered instruction to decoder.
- id_pc_out  out  XLEN  registered PC.
- id_valid_out  out  1  IF/ID holds a real instruction.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rd  in  5  destination register.
- id_alu_ctrl  in  ALU_CTRL_W; id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  decoded controls.
- ex_pc, ex_rs1, ex_rs2, ex_imm  out  XLEN each  ID/EX data.
- ex_rd  out  5.
- ex_alu_ctrl  out  ALU_CTRL_W; ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc_plus_imm  out  XLEN  combinational ex_pc + ex_imm.
- ex_pc_plus_4  out  XLEN  combinational ex_pc + 4.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - id_instr_out = NOP_INSTR; id_pc_out = 0; id_valid_out = 0.
  - All ex_* registers = 0, including ex_valid and all control bits.
- All register updates occur on the rising edge of clk when rst=1. Priority: flush > stall > normal.
- Normal (flush=0, stall=0), one-cycle latency per stage:
  - IF/ID captures if_instr_in, if_pc_in; id_valid_out = 1.
  - ID/EX captures every id_* input; ex_valid = id_valid_out.
- Stall (flush=0, stall=1):
  - IF/ID holds all its values.
  - ID/EX loads a bubble: all control bits = 0, ex_valid = 0, ex_rd = 0.
  - In the bubble, data fields ex_pc, ex_rs1, ex_rs2 and ex_imm are also cleared to 0.
- Flush (flush=1, regardless of stall):
  - IF/ID loads NOP_INSTR, pc 0, valid 0.
  - ID/EX loads a bubble, as for stall.
- A bubble or NOP never has ex_reg_write=1 or ex_mem_write=1.
- Adders: purely combinational from the ID/EX registers.
  - Arithmetic is modulo 2^XLEN; carry is discarded. Example: 0xFFFFFFFC + 8 = 0x00000004.
  - A negative immediate subtracts naturally in two's complement.
- Reset released mid-stream: the first rising edge with rst=1 behaves as a normal/stall/flush edge; there is no extra wait cycle.
- No combinational path from any id_* or if_* input to any output.

Optional Feature:
- Macro PIPE_RS_IDX_EN.
- When defined:
  - Adds inputs id_rs1_idx and id_rs2_idx (5 bits each) and outputs ex_rs1_idx and ex_rs2_idx (5 bits each), for the forwarding unit.
  - The index registers are captured like the other ID/EX fields; they reset to 0 and are cleared to 0 on bubble.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: drive rst=0 mid-cycle with arbitrary inputs -> immediately id_instr_out=0x00000013, id_pc_out=0, ex_valid=0, all ex_* = 0.
- Flow: rst=1; present instr 0x00500093 at pc 0x10, then at the next edge id_imm=5, id_rd=1, id_reg_write=1 -> id_instr_out=0x00500093 after edge 1; after edge 2 ex_pc=0x10, ex_imm=5, ex_rd=1, ex_reg_write=1, ex_valid=1, ex_pc_plus_imm=0x15, ex_pc_plus_4=0x14.
- Stall: assert stall for one edge with IF/ID holding pc 0x20 and new if_pc_in=0x24 -> id_pc_out stays 0x20; ex_valid=0, ex_reg_write=0, ex_mem_write=0; after stall drops, the next edge moves pc 0x20 into EX.
- Flush with stall: assert flush=1, stall=1 together -> id_instr_out=0x00000013, id_valid_out=0, ex_valid=0, all ex controls 0.
- Adder wrap/sign: ex_pc=0xFFFFFFFC with ex_imm=8 -> ex_pc_plus_imm=0x00000004; ex_pc=0x100 with ex_imm=0xFFFFFFF0 -> 0x000000F0.
- PIPE_RS_IDX_EN build: id_rs1_idx=3, id_rs2_idx=7 -> ex_rs1_idx=3, ex_rs2_idx=7 after one edge; both 0 after a stall edge.
